// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Only one transaction is in flight; addresses at or above SYS_LIMIT fault without touching memory.
`timescale 1ns/1ps
module data_mem_arbiter #(
  parameter logic [63:0] USER_LIMIT = 64'h0000_4000,
  parameter logic [63:0] SYS_LIMIT  = 64'h0000_4800
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iReqA,
  input  logic        iWeA,
  input  logic [63:0] iAddrA,
  input  logic [63:0] iWDataA,
  output logic        oAckA,
  output logic        oErrA,
  input  logic        iReqB,
  input  logic        iWeB,
  input  logic [63:0] iAddrB,
  input  logic [63:0] iWDataB,
  output logic        oAckB,
  output logic        oErrB,
  output logic [63:0] oRData,
  output logic [63:0] oMemAddress,
  output logic [63:0] oMemWriteData,
  output logic        oMemRead,
  output logic        oMemWrite,
  input  logic [63:0] iMemData,
  output logic        oBusy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, DONE} stateT;

  stateT       state, nextState;
  logic        lastB, grantB, weLat, faultLat;
  logic [63:0] addrLat, wDataLat, rDataReg;
  logic        pickB, inUser, inSys, addrOk;

  assign oMemAddress   = addrLat;
  assign oMemWriteData = wDataLat;
  assign oRData        = rDataReg;

  // Contention goes to whichever port was not served last.
  always_comb begin
    pickB  = iReqB && !(iReqA && lastB);
    inUser = addrLat < USER_LIMIT;
    inSys  = (addrLat >= USER_LIMIT) && (addrLat < SYS_LIMIT);
    addrOk = inUser || inSys;
  end

  always_comb begin
    nextState = state;
    oMemRead  = 1'b0;
    oMemWrite = 1'b0;
    oAckA     = 1'b0;
    oAckB     = 1'b0;
    oErrA     = 1'b0;
    oErrB     = 1'b0;
    oBusy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (iReqA || iReqB) nextState = ISSUE;
      end
      ISSUE: begin
        if (addrOk) begin
          oMemWrite = weLat;
          oMemRead  = !weLat;
        end
        nextState = (addrOk && !weLat) ? RWAIT : DONE;
      end
      RWAIT: begin
        nextState = DONE;
      end
      DONE: begin
        oAckA     = !grantB;
        oAckB     = grantB;
        oErrA     = !grantB && faultLat;
        oErrB     = grantB && faultLat;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state    <= IDLE;
      lastB    <= 1'b1;
      grantB   <= 1'b0;
      weLat    <= 1'b0;
      faultLat <= 1'b0;
      addrLat  <= '0;
      wDataLat <= '0;
      rDataReg <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (iReqA || iReqB) begin
            grantB   <= pickB;
            addrLat  <= pickB ? iAddrB : iAddrA;
            wDataLat <= pickB ? iWDataB : iWDataA;
            weLat    <= pickB ? iWeB : iWeA;
            faultLat <= 1'b0;
          end
        end
        ISSUE:   faultLat <= !addrOk;
        RWAIT:   rDataReg <= iMemData;
        DONE:    lastB    <= grantB;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized transactions checked against a transaction-level model with a shadow memory.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

  logic        iCLK, iRST_n;
  logic        iReqA, iWeA, iReqB, iWeB;
  logic [63:0] iAddrA, iWDataA, iAddrB, iWDataB;
  logic        oAckA, oErrA, oAckB, oErrB;
  logic [63:0] oRData, oMemAddress, oMemWriteData, iMemData;
  logic        oMemRead, oMemWrite, oBusy;

  data_mem_arbiter #(.USER_LIMIT(64'h0000_4000), .SYS_LIMIT(64'h0000_4800)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .iReqA(iReqA), .iWeA(iWeA), .iAddrA(iAddrA), .iWDataA(iWDataA), .oAckA(oAckA), .oErrA(oErrA),
    .iReqB(iReqB), .iWeB(iWeB), .iAddrB(iAddrB), .iWDataB(iWDataB), .oAckB(oAckB), .oErrB(oErrB),
    .oRData(oRData), .oMemAddress(oMemAddress), .oMemWriteData(oMemWriteData),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .iMemData(iMemData), .oBusy(oBusy)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int nCmp = 0;
  int nBad = 0;
  int viol = 0;
  bit prevWrite = 1'b0;

  // External memory: read data appears the cycle after the read strobe.
  logic [63:0] memStore [logic [63:0]];
  logic [63:0] memQ;
  assign iMemData = memQ;

  function automatic logic [63:0] memDefault(input logic [63:0] a);
    return ~a ^ 64'h5A5A_0000_C3C3_0000;
  endfunction

  always @(posedge iCLK) begin
    if (oMemWrite) memStore[oMemAddress] = oMemWriteData;
    if (oMemRead) memQ <= memStore.exists(oMemAddress) ? memStore[oMemAddress] : memDefault(oMemAddress);
  end

  always @(negedge iCLK) begin
    if (oAckA && oAckB) viol++;
    if (oMemWrite && prevWrite) viol++;
    if ((oMemWrite || oMemRead) && oMemAddress >= 64'h4800) viol++;
    prevWrite = oMemWrite;
  end

  // Reference model state
  logic [63:0] refMem [logic [63:0]];
  bit          lastBM;
  logic [63:0] rdM;

  function automatic logic [63:0] modelRead(input logic [63:0] a);
    return refMem.exists(a) ? refMem[a] : memDefault(a);
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic issue(input bit rA, input bit wA, input logic [63:0] aA, input logic [63:0] dA,
                       input bit rB, input bit wB, input logic [63:0] aB, input logic [63:0] dB);
    @(negedge iCLK);
    iReqA = rA; iWeA = wA; iAddrA = aA; iWDataA = dA;
    iReqB = rB; iWeB = wB; iAddrB = aB; iWDataB = dB;
  endtask

  task automatic runTxn(input string nm, input bit expB, input int expLat, input bit expErr,
                        input logic [63:0] expAddr, input logic [63:0] expRd, input int dropK);
    int gotK, stK;
    bit gotB, gotErr, busy1;
    logic [63:0] gotRd, stA;
    gotK = 0; stK = 0; gotB = 0; gotErr = 0; busy1 = 0; gotRd = '0; stA = '0;
    @(posedge iCLK);
    for (int k = 1; k <= 6 && gotK == 0; k++) begin
      @(negedge iCLK);
      if (k == 1) busy1 = oBusy;
      if ((oMemRead || oMemWrite) && stK == 0) begin
        stK = k;
        stA = oMemAddress;
      end
      if (oAckA || oAckB) begin
        gotK = k; gotB = oAckB; gotErr = oAckB ? oErrB : oErrA; gotRd = oRData;
      end
      if (k == dropK) begin iReqA = 0; iReqB = 0; end
    end
    iReqA = 0; iReqB = 0;
    check({nm, ".port"}, gotB, expB);
    check({nm, ".lat"}, gotK, expLat);
    check({nm, ".err"}, gotErr, expErr);
    check({nm, ".busy"}, busy1, 1);
    check({nm, ".strobeCyc"}, stK, expErr ? 0 : 1);
    if (!expErr) check({nm, ".strobeAddr"}, stA, expAddr);
    check({nm, ".rdata"}, gotRd, expRd);
  endtask

  task automatic doReset();
    @(negedge iCLK);
    iRST_n = 0; iReqA = 0; iReqB = 0;
    repeat (2) @(negedge iCLK);
    iRST_n = 1;
    lastBM = 1;
    rdM = '0;
  endtask

  function automatic logic [63:0] pickAddr();
    logic [63:0] bnd [4];
    bnd[0] = 64'h3FFF; bnd[1] = 64'h4000; bnd[2] = 64'h47FF; bnd[3] = 64'h4800;
    if ($urandom_range(0, 5) == 0) return bnd[$urandom_range(0, 3)];
    return 64'($urandom_range(0, 'h4FF)) << 4;
  endfunction

  typedef struct {
    bit rA; bit wA; logic [63:0] aA; logic [63:0] dA;
    bit rB; bit wB; logic [63:0] aB; logic [63:0] dB;
    bit expB; int expLat; bit expErr; logic [63:0] expRd;
  } vecT;

  vecT vecs [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  rq;
    bit          rA, rB, wA, wB, winB, ww, fault;
    logic [63:0] aA, aB, dA, dB, wa, wd;
    int          nAck, acks, lat;
    bit          grantSeq [8];

    iRST_n = 1; iReqA = 0; iWeA = 0; iAddrA = '0; iWDataA = '0;
    iReqB = 0; iWeB = 0; iAddrB = '0; iWDataB = '0;

    // rA wA aA dA | rB wB aB dB | expB lat err rdata (pointer starts at B after reset)
    vecs[0]  = '{1, 1, 64'h10,   64'hDEAD, 0, 0, 64'h0,   64'h0,    0, 2, 0, 64'h0};
    vecs[1]  = '{0, 0, 64'h0,    64'h0,    1, 1, 64'h4000, 64'h1234, 1, 2, 0, 64'h0};
    vecs[2]  = '{0, 0, 64'h0,    64'h0,    1, 0, 64'h4000, 64'h0,    1, 3, 0, 64'h1234};
    vecs[3]  = '{1, 1, 64'h4800, 64'h9999, 0, 0, 64'h0,   64'h0,    0, 2, 1, 64'h1234};
    vecs[4]  = '{1, 1, 64'h3FFF, 64'h1111, 0, 0, 64'h0,   64'h0,    0, 2, 0, 64'h1234};
    vecs[5]  = '{1, 1, 64'h47FF, 64'h2222, 0, 0, 64'h0,   64'h0,    0, 2, 0, 64'h1234};
    vecs[6]  = '{1, 0, 64'h3FFF, 64'h0,    0, 0, 64'h0,   64'h0,    0, 3, 0, 64'h1111};
    vecs[7]  = '{1, 0, 64'h47FF, 64'h0,    0, 0, 64'h0,   64'h0,    0, 3, 0, 64'h2222};
    vecs[8]  = '{1, 1, 64'h100,  64'hAAAA, 1, 1, 64'h200, 64'hBBBB, 1, 2, 0, 64'h2222};
    vecs[9]  = '{1, 0, 64'h3FFF, 64'h0,    1, 0, 64'h4000, 64'h0,    0, 3, 0, 64'h1111};
    vecs[10] = '{0, 0, 64'h0,    64'h0,    1, 0, 64'h4800, 64'h0,    1, 2, 1, 64'h1111};
    vecs[11] = '{1, 1, 64'h4800, 64'h7777, 0, 0, 64'h0,   64'h0,    0, 2, 1, 64'h1111};

    doReset();
    check("reset.ctrl", {oAckA, oAckB, oErrA, oErrB, oMemRead, oMemWrite, oBusy}, 0);
    check("reset.rdata", oRData, 0);
    check("reset.memAddr", oMemAddress, 0);
    check("reset.memWData", oMemWriteData, 0);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].rA, vecs[i].wA, vecs[i].aA, vecs[i].dA, vecs[i].rB, vecs[i].wB, vecs[i].aB, vecs[i].dB);
      wa = vecs[i].expB ? vecs[i].aB : vecs[i].aA;
      runTxn($sformatf("vec%0d", i), vecs[i].expB, vecs[i].expLat, vecs[i].expErr, wa, vecs[i].expRd, 0);
      ww = vecs[i].expB ? vecs[i].wB : vecs[i].wA;
      if (ww && !vecs[i].expErr) refMem[wa] = vecs[i].expB ? vecs[i].dB : vecs[i].dA;
    end
    lastBM = 0;
    rdM = 64'h1111;

    // Request withdrawn right after being latched still completes.
    issue(1, 1, 64'h30, 64'h3030, 0, 0, 64'h0, 64'h0);
    runTxn("drop", 0, 2, 0, 64'h30, rdM, 1);
    refMem[64'h30] = 64'h3030;
    lastBM = 0;

    // Both ports held continuously: grants must alternate, A first after reset.
    doReset();
    iReqA = 1; iWeA = 1; iAddrA = 64'h800; iWDataA = 64'hAAAA_0001;
    iReqB = 1; iWeB = 1; iAddrB = 64'h900; iWDataB = 64'hBBBB_0002;
    nAck = 0;
    for (int c = 0; c < 40 && nAck < 8; c++) begin
      @(negedge iCLK);
      if (oAckA || oAckB) begin
        grantSeq[nAck] = oAckB;
        nAck++;
      end
    end
    iReqA = 0; iReqB = 0;
    check("alt.count", nAck, 8);
    for (int g = 0; g < 8; g++)
      if (g < nAck) check($sformatf("alt.grant%0d", g), grantSeq[g], g % 2);
    refMem[64'h800] = 64'hAAAA_0001;
    refMem[64'h900] = 64'hBBBB_0002;
    lastBM = 1;

    // Reset asserted while a read waits for memory data aborts it silently.
    issue(1, 0, 64'h10, 64'h0, 0, 0, 64'h0, 64'h0);
    @(posedge iCLK);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_n = 0; iReqA = 0;
    @(negedge iCLK);
    check("rstRwait.ctrl", {oBusy, oAckA, oAckB, oMemRead, oMemWrite}, 0);
    check("rstRwait.rdata", oRData, 0);
    iRST_n = 1;
    acks = 0;
    repeat (3) begin
      @(negedge iCLK);
      if (oAckA || oAckB) acks++;
    end
    check("rstRwait.noAck", acks, 0);
    lastBM = 1;
    rdM = '0;
    issue(0, 0, 64'h0, 64'h0, 1, 0, 64'h4000, 64'h0);
    rdM = modelRead(64'h4000);
    runTxn("afterRst", 1, 3, 0, 64'h4000, rdM, 0);
    lastBM = 1;

    // Randomized transactions against the transaction-level model.
    for (int it = 0; it < 200; it++) begin
      rq = 2'($urandom_range(1, 3));
      rA = rq[0]; rB = rq[1];
      wA = 1'($urandom_range(0, 1)); wB = 1'($urandom_range(0, 1));
      aA = pickAddr(); aB = pickAddr();
      dA = {$urandom, $urandom}; dB = {$urandom, $urandom};
      if (rA && rB) winB = !lastBM;
      else          winB = rB;
      wa = winB ? aB : aA;
      wd = winB ? dB : dA;
      ww = winB ? wB : wA;
      fault = (wa >= 64'h4800);
      if (!fault && !ww) rdM = modelRead(wa);
      lat = (ww || fault) ? 2 : 3;
      issue(rA, wA, aA, dA, rB, wB, aB, dB);
      runTxn($sformatf("rnd%0d", it), winB, lat, fault, wa, rdM, 0);
      if (!fault && ww) refMem[wa] = wd;
      lastBM = winB;
    end

    check("protocolViolations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
